// File: rtl/alu_share_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one registered ALU between two valid/ready requesters.
//            Define ARB_FIXED_PRIO_EN for fixed priority to requester 0.
// Revision : 1.0 - initial release
// =============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_modo,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_c,
  output logic             rsp0_rco,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_modo,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_c,
  output logic             rsp1_rco,

  output logic [1:0]       alu_modo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_rco
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] c_lat_load = 3'(LAT);

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_owner;
  logic [1:0]       r_alu_modo;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_rsp0_valid;
  logic [WIDTH-1:0] r_rsp0_c;
  logic             r_rsp0_rco;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp1_c;
  logic             r_rsp1_rco;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;

  assign w_idle = (r_state == ST_IDLE);

`ifdef ARB_FIXED_PRIO_EN
  assign w_grant0 = req0_valid;
  assign w_grant1 = req1_valid & ~req0_valid;
`else
  // r_ptr = 1 means requester 1 is favoured on a simultaneous request
  logic r_ptr;

  assign w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
  assign w_grant1 = req1_valid & (~req0_valid |  r_ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= w_grant0;
    end
  end
`endif

  assign w_accept = w_idle & (w_grant0 | w_grant1);

  // Gated with rst so no grant is visible while reset is held
  assign req0_ready = rst & w_idle & w_grant0;
  assign req1_ready = rst & w_idle & w_grant1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_owner      <= 1'b0;
      r_alu_modo   <= 2'd0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp0_c     <= '0;
      r_rsp0_rco   <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_c     <= '0;
      r_rsp1_rco   <= 1'b0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_grant0) begin
              r_alu_modo <= req0_modo;
              r_alu_a    <= req0_a;
              r_alu_b    <= req0_b;
            end else begin
              r_alu_modo <= req1_modo;
              r_alu_a    <= req1_a;
              r_alu_b    <= req1_b;
            end
            r_owner <= w_grant1;
            r_cnt   <= c_lat_load;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            if (r_owner) begin
              r_rsp1_c     <= alu_c;
              r_rsp1_rco   <= alu_rco;
              r_rsp1_valid <= 1'b1;
            end else begin
              r_rsp0_c     <= alu_c;
              r_rsp0_rco   <= alu_rco;
              r_rsp0_valid <= 1'b1;
            end
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_modo   = r_alu_modo;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_c     = r_rsp0_c;
  assign rsp0_rco   = r_rsp0_rco;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_c     = r_rsp1_c;
  assign rsp1_rco   = r_rsp1_rco;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed self-checking bench for alu_share_arbiter with an ALU model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_alu_share_arbiter;
  localparam int WIDTH = 4;
  parameter  int LAT   = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [1:0]       req0_modo = 2'd0, req1_modo = 2'd0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             rsp0_valid, rsp1_valid, rsp0_rco, rsp1_rco;
  logic [WIDTH-1:0] rsp0_c, rsp1_c;
  logic [1:0]       alu_modo;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic             alu_rco;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_modo(req0_modo),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_c(rsp0_c), .rsp0_rco(rsp0_rco),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_modo(req1_modo),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_c(rsp1_c), .rsp1_rco(rsp1_rco),
    .alu_modo(alu_modo), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_rco(alu_rco)
  );

  // Registered ALU: 00 add, 01 sub (rco = borrow), 10 and, 11 or; LAT stages
  logic [WIDTH:0] alu_next;
  logic [WIDTH:0] pipe [LAT];
  always_comb begin
    case (alu_modo)
      2'b00:   alu_next = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_next = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_next = {1'b0, alu_a & alu_b};
      default: alu_next = {1'b0, alu_a | alu_b};
    endcase
  end
  always @(posedge clk) begin
    pipe[0] <= alu_next;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_c   = pipe[LAT-1][WIDTH-1:0];
  assign alu_rco = pipe[LAT-1][WIDTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples grants before the edge, then advances past it
  task automatic step_accept(output logic g0, output logic g1);
    #1;
    g0 = req0_ready;
    g1 = req1_ready;
    tick();
  endtask

  task automatic wait_rsp(input int maxc, output int lat, output logic v0,
                          output logic v1, output logic rdy);
    lat = -1; v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      if (req0_ready || req1_ready) rdy = 1'b1;
      if (rsp0_valid || rsp1_valid) begin
        lat = k; v0 = rsp0_valid; v1 = rsp1_valid;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 4'd9; req1_a = 4'd6;
    tick(); tick();
    n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b expected 0", req1_ready); end
    n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); end
    n_checks++; if ({alu_modo, alu_a, alu_b} !== 10'd0) begin n_fail++; $display("FAIL reset_alu: got %h expected 0", {alu_modo, alu_a, alu_b}); end
    n_checks++; if ({rsp0_c, rsp0_rco, rsp1_c, rsp1_rco} !== 10'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", {rsp0_c, rsp0_rco, rsp1_c, rsp1_rco}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req1_a = '0;
    rst = 1'b1;
  endtask

  task automatic test_single0();
    logic g0, g1, v0, v1, rdy; int lat;
    req0_valid = 1'b1; req0_modo = 2'b00; req0_a = 4'd2; req0_b = 4'd3;
    step_accept(g0, g1);
    req0_valid = 1'b0;
    n_checks++; if ({g0, g1} !== 2'b10) begin n_fail++; $display("FAIL s0_grant: got %b expected 10", {g0, g1}); end
    n_checks++; if ({alu_a, alu_b} !== {4'd2, 4'd3}) begin n_fail++; $display("FAIL s0_alu_ops: got %h expected 23", {alu_a, alu_b}); end
    wait_rsp(LAT + 5, lat, v0, v1, rdy);
    n_checks++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL s0_latency: got %0d expected %0d", lat, LAT + 1); end
    n_checks++; if ({v0, v1} !== 2'b10) begin n_fail++; $display("FAIL s0_rsp_valid: got %b expected 10", {v0, v1}); end
    n_checks++; if ({rsp0_rco, rsp0_c} !== 5'd5) begin n_fail++; $display("FAIL s0_result: got %h expected 05", {rsp0_rco, rsp0_c}); end
    tick();
    n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL s0_pulse_width: got %b expected 0", rsp0_valid); end
  endtask

  task automatic test_single1();
    logic g0, g1, v0, v1, rdy; int lat;
    req1_valid = 1'b1; req1_modo = 2'b00; req1_a = 4'd15; req1_b = 4'd1;
    step_accept(g0, g1);
    req1_valid = 1'b0;
    n_checks++; if ({g0, g1} !== 2'b01) begin n_fail++; $display("FAIL s1_grant: got %b expected 01", {g0, g1}); end
    wait_rsp(LAT + 5, lat, v0, v1, rdy);
    n_checks++; if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL s1_rsp_valid: got %b expected 01", {v0, v1}); end
    n_checks++; if ({rsp1_rco, rsp1_c} !== 5'h10) begin n_fail++; $display("FAIL s1_result: got %h expected 10", {rsp1_rco, rsp1_c}); end
    n_checks++; if ({rsp0_rco, rsp0_c} !== 5'd5) begin n_fail++; $display("FAIL s1_rsp0_hold: got %h expected 05", {rsp0_rco, rsp0_c}); end
    tick();
  endtask

  task automatic test_both();
    logic g0, g1, v0, v1, rdy, e0; int lat;
    req0_valid = 1'b1; req0_modo = 2'b00; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_modo = 2'b10; req1_a = 4'd12; req1_b = 4'd10;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      e0 = 1'b1;
`else
      e0 = ((i % 2) == 0);
`endif
      step_accept(g0, g1);
      n_checks++; if ({g0, g1} !== {e0, ~e0}) begin n_fail++; $display("FAIL both_grant%0d: got %b expected %b", i, {g0, g1}, {e0, ~e0}); end
      wait_rsp(LAT + 5, lat, v0, v1, rdy);
      n_checks++; if ({v0, v1, rdy} !== {e0, ~e0, 1'b0}) begin n_fail++; $display("FAIL both_rsp%0d: got v/rdy %b expected %b", i, {v0, v1, rdy}, {e0, ~e0, 1'b0}); end
      if (e0) begin
        n_checks++; if ({rsp0_rco, rsp0_c} !== 5'd3) begin n_fail++; $display("FAIL both_c0_%0d: got %h expected 03", i, {rsp0_rco, rsp0_c}); end
      end else begin
        n_checks++; if ({rsp1_rco, rsp1_c} !== 5'd8) begin n_fail++; $display("FAIL both_c1_%0d: got %h expected 08", i, {rsp1_rco, rsp1_c}); end
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_hold_operands();
    logic g0, g1, v0, v1, rdy; int lat;
    req0_valid = 1'b1; req0_modo = 2'b00; req0_a = 4'd3; req0_b = 4'd10;
    step_accept(g0, g1);
    req0_valid = 1'b0; req0_modo = 2'b11; req0_a = 4'd15; req0_b = 4'd15;
    n_checks++; if (g0 !== 1'b1) begin n_fail++; $display("FAIL hold_grant: got %b expected 1", g0); end
    tick();
    n_checks++; if ({alu_modo, alu_a, alu_b} !== {2'b00, 4'd3, 4'd10}) begin n_fail++; $display("FAIL hold_alu_in_wait: got %h expected 03a", {alu_modo, alu_a, alu_b}); end
    wait_rsp(LAT + 5, lat, v0, v1, rdy);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL hold_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if ({rsp0_rco, rsp0_c} !== 5'd13) begin n_fail++; $display("FAIL hold_result: got %h expected 0d", {rsp0_rco, rsp0_c}); end
    n_checks++; if ({alu_a, alu_b} !== {4'd3, 4'd10}) begin n_fail++; $display("FAIL hold_alu_after: got %h expected 3a", {alu_a, alu_b}); end
    tick();
  endtask

  task automatic test_async_reset();
    logic g0, g1, v0, v1, rdy, seen; int lat;
    req0_valid = 1'b1; req0_modo = 2'b01; req0_a = 4'd9; req0_b = 4'd4;
    step_accept(g0, g1);
    req0_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    n_checks++; if ({alu_modo, alu_a, alu_b} !== 10'd0) begin n_fail++; $display("FAIL arst_alu: got %h expected 0", {alu_modo, alu_a, alu_b}); end
    n_checks++; if ({rsp0_c, rsp0_rco, rsp1_c, rsp1_rco} !== 10'd0) begin n_fail++; $display("FAIL arst_rsp_data: got %h expected 0", {rsp0_c, rsp0_rco, rsp1_c, rsp1_rco}); end
    seen = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      if (rsp0_valid || rsp1_valid || req0_ready || req1_ready) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL arst_no_pulse: got %b expected 0", seen); end
    rst = 1'b1;
    req0_valid = 1'b1; req0_modo = 2'b00; req0_a = 4'd6; req0_b = 4'd7;
    step_accept(g0, g1);
    req0_valid = 1'b0;
    n_checks++; if ({g0, g1} !== 2'b10) begin n_fail++; $display("FAIL arst_regrant: got %b expected 10", {g0, g1}); end
    wait_rsp(LAT + 5, lat, v0, v1, rdy);
    n_checks++; if ({lat == LAT + 1, v0, rsp0_rco, rsp0_c} !== {1'b1, 1'b1, 5'd13}) begin n_fail++; $display("FAIL arst_recover: got lat %0d v %b c %h expected lat %0d v 1 c 0d", lat, v0, {rsp0_rco, rsp0_c}, LAT + 1); end
    tick();
  endtask

  task automatic test_latency();
    logic g0, g1, v0, v1, rdy; int lat;
    req1_valid = 1'b1; req1_modo = 2'b01; req1_a = 4'd3; req1_b = 4'd5;
    step_accept(g0, g1);
    n_checks++; if ({g0, g1} !== 2'b01) begin n_fail++; $display("FAIL lat_grant: got %b expected 01", {g0, g1}); end
    wait_rsp(LAT + 5, lat, v0, v1, rdy);
    n_checks++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL lat_edges: got %0d expected %0d", lat, LAT + 1); end
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL lat_ready_busy: got %b expected 0", rdy); end
    n_checks++; if ({v1, rsp1_rco, rsp1_c} !== {1'b1, 5'h1e}) begin n_fail++; $display("FAIL lat_result: got v %b c %h expected v 1 c 1e", v1, {rsp1_rco, rsp1_c}); end
    tick();
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL lat_next_ready: got %b expected 1", req1_ready); end
    req1_valid = 1'b0;
    n_checks++; if ({rsp0_rco, rsp0_c} !== 5'd13) begin n_fail++; $display("FAIL lat_rsp0_hold: got %h expected 0d", {rsp0_rco, rsp0_c}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single0();
    test_single1();
    test_both();
    test_hold_operands();
    test_async_reset();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
